// File: rtl/v_interface_pkg.sv
// -----------------------------------------------------------------------------
// v_interface_pkg
// Shared definitions for the host-to-board virtual interface blocks:
//   - chunk type byte values for every virtual peripheral on the link
//   - chunk length (type byte + payload byte)
//   - receive framer state encoding
//   - default inter-byte timeout and its counter width
//   - saturating 8-bit increment used by the error counters
// -----------------------------------------------------------------------------
package v_interface_pkg;

   localparam logic [7:0] CHUNK_TYPE_LEDS     = 8'd2;
   localparam logic [7:0] CHUNK_TYPE_SWITCHES = 8'd3;

   localparam int CHUNK_LEN = 2;

   localparam int DEFAULT_TIMEOUT_CYCLES = 100000;
   localparam int DEFAULT_TIMEOUT_WIDTH  = 17;

   typedef enum logic [0:0] {
      RX_IDLE         = 1'b0,
      RX_WAIT_PAYLOAD = 1'b1
   } rx_state_t;

   // Increment that sticks at 0xFF instead of wrapping.
   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      if (value == 8'hFF) begin
         return value;
      end else begin
         return value + 8'd1;
      end
   endfunction

endpackage

// File: rtl/v_chunk_rx.sv
// -----------------------------------------------------------------------------
// v_chunk_rx
// Generic two-byte chunk framer for the UART receive stream. The first byte
// of a frame is the chunk type, the second the payload. On the payload byte
// it raises chunk_valid for that same cycle with chunk_type (latched type
// byte) and chunk_byte (the payload, straight from rx_byte), so the stage
// above can register its result on the very edge the payload arrives.
// A frame whose payload does not arrive within TIMEOUT_CYCLES edges of the
// type byte is dropped and counted in error_count (saturating).
//
// Ports:
//   CLK          in   clock
//   reset        in   synchronous, active-high reset
//   rx_valid     in   one-cycle strobe, rx_byte holds a received byte
//   rx_byte      in   [7:0] received byte
//   chunk_valid  out  payload of a complete chunk is on chunk_byte this cycle
//   chunk_type   out  [7:0] type byte of the current frame (registered)
//   chunk_byte   out  [7:0] payload byte (valid with chunk_valid)
//   error_count  out  [7:0] frames dropped by timeout, saturating (registered)
// -----------------------------------------------------------------------------
module v_chunk_rx
   import v_interface_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   parameter int TIMEOUT_WIDTH  = DEFAULT_TIMEOUT_WIDTH
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic       rx_valid,
   input  logic [7:0] rx_byte,
   output logic       chunk_valid,
   output logic [7:0] chunk_type,
   output logic [7:0] chunk_byte,
   output logic [7:0] error_count
);

   // The counter is cleared on the type byte, so the edge that sees it at
   // TIMEOUT_CYCLES-1 is exactly TIMEOUT_CYCLES edges after the type byte.
   localparam logic [TIMEOUT_WIDTH-1:0] TERMINAL_COUNT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

   rx_state_t                state;
   rx_state_t                state_next;
   logic [TIMEOUT_WIDTH-1:0] idle_count;
   logic                     timeout_hit;

   assign chunk_byte = rx_byte;

   // State register.
   always_ff @(posedge CLK) begin
      if (reset) begin
         state <= RX_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode; a byte arriving on the terminal cycle wins over the timeout.
   always_comb begin
      state_next  = state;
      chunk_valid = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         RX_IDLE: begin
            if (rx_valid) begin
               state_next = RX_WAIT_PAYLOAD;
            end else begin
               state_next = RX_IDLE;
            end
         end
         RX_WAIT_PAYLOAD: begin
            if (rx_valid) begin
               state_next  = RX_IDLE;
               chunk_valid = 1'b1;
            end else if (idle_count == TERMINAL_COUNT) begin
               state_next  = RX_IDLE;
               timeout_hit = 1'b1;
            end else begin
               state_next = RX_WAIT_PAYLOAD;
            end
         end
         default: begin
            state_next = RX_IDLE;
         end
      endcase
   end

   // Type latch, inter-byte idle counter and dropped-frame counter.
   always_ff @(posedge CLK) begin
      if (reset) begin
         chunk_type  <= 8'h00;
         idle_count  <= '0;
         error_count <= 8'h00;
      end else begin
         if ((state == RX_IDLE) && rx_valid) begin
            chunk_type <= rx_byte;
            idle_count <= '0;
         end else if ((state == RX_WAIT_PAYLOAD) && !rx_valid && !timeout_hit) begin
            idle_count <= idle_count + TIMEOUT_WIDTH'(1);
         end else begin
            idle_count <= idle_count;
         end
         if (timeout_hit) begin
            error_count <= sat_inc8(error_count);
         end else begin
            error_count <= error_count;
         end
      end
   end

endmodule

// File: rtl/v_switches.sv
// -----------------------------------------------------------------------------
// v_switches
// Host-to-board virtual switch bank. Frames the UART byte stream with
// v_chunk_rx and, when a chunk addressed to INTERFACE_RX_CHUNK_TYPE carries a
// payload different from the current switch state, loads it onto SWITCHES
// and pulses updated for one cycle. Chunks for other interfaces are dropped.
//
// Ports:
//   CLK          in   clock
//   reset        in   synchronous, active-high reset
//   rx_valid     in   one-cycle strobe, rx_byte holds a received byte
//   rx_byte      in   [7:0] received byte
//   SWITCHES     out  [7:0] current virtual switch state (registered)
//   updated      out  one-cycle pulse when SWITCHES takes a new value
//   error_count  out  [7:0] frames dropped by timeout, saturating
// -----------------------------------------------------------------------------
module v_switches
   import v_interface_pkg::*;
#(
   parameter logic [7:0] INTERFACE_RX_CHUNK_TYPE = CHUNK_TYPE_SWITCHES,
   parameter int         TIMEOUT_CYCLES          = DEFAULT_TIMEOUT_CYCLES,
   parameter int         TIMEOUT_WIDTH           = DEFAULT_TIMEOUT_WIDTH
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic       rx_valid,
   input  logic [7:0] rx_byte,
   output logic [7:0] SWITCHES,
   output logic       updated,
   output logic [7:0] error_count
);

   logic       chunk_valid;
   logic [7:0] chunk_type;
   logic [7:0] chunk_byte;
   logic       load_switches;

   v_chunk_rx #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
   ) u_chunk_rx (
      .CLK         (CLK),
      .reset       (reset),
      .rx_valid    (rx_valid),
      .rx_byte     (rx_byte),
      .chunk_valid (chunk_valid),
      .chunk_type  (chunk_type),
      .chunk_byte  (chunk_byte),
      .error_count (error_count)
   );

   // Only a payload for this interface that actually changes the state counts.
   assign load_switches = chunk_valid
                          && (chunk_type == INTERFACE_RX_CHUNK_TYPE)
                          && (chunk_byte != SWITCHES);

   // Switch state register and its change pulse.
   always_ff @(posedge CLK) begin
      if (reset) begin
         SWITCHES <= 8'h00;
         updated  <= 1'b0;
      end else if (load_switches) begin
         SWITCHES <= chunk_byte;
         updated  <= 1'b1;
      end else begin
         SWITCHES <= SWITCHES;
         updated  <= 1'b0;
      end
   end

endmodule
